// File: rtl/conv_window_accumulator.sv
// Binary-weight 3x3 convolution accumulator: sums TI channel slices per output pixel
// and presents each pixel on a valid/ready port with coordinates and a requantised activation.
module conv_window_accumulator #(
    parameter int TI         = 3,
    parameter int INPUT_SIZE = 16,
    parameter int ACC_W      = 16,
    parameter int SHIFT      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    window_valid,
    input  logic [5:0]              x11,
    input  logic [5:0]              x12,
    input  logic [5:0]              x13,
    input  logic [5:0]              x21,
    input  logic [5:0]              x22,
    input  logic [5:0]              x23,
    input  logic [5:0]              x31,
    input  logic [5:0]              x32,
    input  logic [5:0]              x33,
    input  logic                    w11,
    input  logic                    w12,
    input  logic                    w13,
    input  logic                    w21,
    input  logic                    w22,
    input  logic                    w23,
    input  logic                    w31,
    input  logic                    w32,
    input  logic                    w33,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic [5:0]              out_act,
    output logic [8:0]              out_col,
    output logic [8:0]              out_row,
    output logic                    frame_done,
    output logic                    overflow,
    output logic                    busy
);

    localparam int              CNT_W    = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TI - 1);
    localparam logic [8:0]      LAST_POS = 9'(INPUT_SIZE - 3);

    logic [5:0]              x_arr [9];
    logic [8:0]              w_vec;

    logic signed [10:0]      partial_q, partial_d, window_sum;
    logic                    p_valid_q, p_valid_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        chan_cnt_q, chan_cnt_d;
    logic signed [ACC_W-1:0] partial_ext, result_sum;
    logic                    complete;

    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [8:0]              col_q, col_d, row_q, row_d;
    logic                    overflow_q, overflow_d;
    logic                    accept;
    logic signed [ACC_W-1:0] shifted;

    assign x_arr = '{x11, x12, x13, x21, x22, x23, x31, x32, x33};
    assign w_vec = {w33, w32, w31, w23, w22, w21, w13, w12, w11};

    // Stage 1: signed dot product of the window against +/-1 weights.
    always_comb begin
        window_sum = '0;
        for (int i = 0; i < 9; i++) begin
            if (w_vec[i]) window_sum = window_sum + $signed({5'b0, x_arr[i]});
            else          window_sum = window_sum - $signed({5'b0, x_arr[i]});
        end
        p_valid_d = window_valid;
        partial_d = window_valid ? window_sum : partial_q;
    end

    // Stage 2: the final slice of a group bypasses acc so the pixel leaves without an extra cycle.
    always_comb begin
        partial_ext = {{(ACC_W-11){partial_q[10]}}, partial_q};
        result_sum  = acc_q + partial_ext;
        acc_d       = acc_q;
        chan_cnt_d  = chan_cnt_q;
        complete    = 1'b0;
        if (p_valid_q) begin
            if (chan_cnt_q == LAST_CNT) begin
                complete   = 1'b1;
                acc_d      = '0;
                chan_cnt_d = '0;
            end else begin
                acc_d      = result_sum;
                chan_cnt_d = chan_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        accept      = out_valid_q && out_ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        col_d       = col_q;
        row_d       = row_q;
        overflow_d  = overflow_q;
        if (accept) begin
            out_valid_d = 1'b0;
            if (col_q == LAST_POS) begin
                col_d = '0;
                row_d = (row_q == LAST_POS) ? 9'd0 : row_q + 9'd1;
            end else begin
                col_d = col_q + 9'd1;
            end
        end
        // A pixel that finds the result register still occupied is lost, not queued.
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = result_sum;
            end else begin
                overflow_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_q   <= '0;
            p_valid_q   <= 1'b0;
            acc_q       <= '0;
            chan_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            partial_q   <= partial_d;
            p_valid_q   <= p_valid_d;
            acc_q       <= acc_d;
            chan_cnt_q  <= chan_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            col_q       <= col_d;
            row_q       <= row_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        shifted = out_data_q >>> SHIFT;
        if (shifted[ACC_W-1])            out_act = 6'd0;
        else if (|shifted[ACC_W-2:6])    out_act = 6'd63;
        else                             out_act = shifted[5:0];
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_col    = col_q;
    assign out_row    = row_q;
    assign overflow   = overflow_q;
    assign frame_done = out_valid_q && (col_q == LAST_POS) && (row_q == LAST_POS);
    assign busy       = (chan_cnt_q != '0) || p_valid_q;

endmodule

// File: tb/tb_conv_window_accumulator.sv
// Directed self-checking bench for conv_window_accumulator (TI=3, 16x16 input, 14x14 output).
module tb_conv_window_accumulator;

    logic              clk;
    logic              rst_n;
    logic              window_valid;
    logic [5:0]        x [9];
    logic [8:0]        wv;
    logic              out_ready;
    logic              out_valid;
    logic signed [15:0] out_data;
    logic [5:0]        out_act;
    logic [8:0]        out_col;
    logic [8:0]        out_row;
    logic              frame_done;
    logic              overflow;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int exp_col = 0;
    int exp_row = 0;

    conv_window_accumulator #(.TI(3), .INPUT_SIZE(16), .ACC_W(16), .SHIFT(5)) dut (
        .clk(clk), .rst_n(rst_n), .window_valid(window_valid),
        .x11(x[0]), .x12(x[1]), .x13(x[2]), .x21(x[3]), .x22(x[4]),
        .x23(x[5]), .x31(x[6]), .x32(x[7]), .x33(x[8]),
        .w11(wv[0]), .w12(wv[1]), .w13(wv[2]), .w21(wv[3]), .w22(wv[4]),
        .w23(wv[5]), .w31(wv[6]), .w32(wv[7]), .w33(wv[8]),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_act(out_act), .out_col(out_col), .out_row(out_row),
        .frame_done(frame_done), .overflow(overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_slice(input logic [5:0] xv, input logic [8:0] wm, input logic vld);
        for (int i = 0; i < 9; i++) x[i] = xv;
        wv = wm;
        window_valid = vld;
    endtask

    task automatic advance_coord();
        if (exp_col == 13) begin
            exp_col = 0;
            exp_row = (exp_row == 13) ? 0 : exp_row + 1;
        end else begin
            exp_col = exp_col + 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        set_slice(6'd63, 9'h1FF, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("[TB] FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (out_act !== 6'd0) begin errors++; $display("[TB] FAIL reset_out_act: got %0d expected 0", out_act); end
        checks++; if (out_col !== 9'd0 || out_row !== 9'd0) begin errors++; $display("[TB] FAIL reset_coord: got (%0d,%0d) expected (0,0)", out_col, out_row); end
        checks++; if (frame_done !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got frame_done=%0b overflow=%0b expected 0/0", frame_done, overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        set_slice(6'd0, 9'h000, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL release_idle: got out_valid=%0b busy=%0b expected 0/0", out_valid, busy); end
        exp_col = 0; exp_row = 0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); set_slice(6'd63, 9'h1FF, 1'b1);
        end
        @(negedge clk); set_slice(6'd0, 9'h000, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got out_valid=%0b expected 0", out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_inflight: got %0b expected 1", busy); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_ontime: got out_valid=%0b expected 1", out_valid); end
        checks++; if (out_data !== 16'sd1701) begin errors++; $display("[TB] FAIL max_data: got %0d expected 1701", out_data); end
        checks++; if (out_act !== 6'd53) begin errors++; $display("[TB] FAIL max_act: got %0d expected 53", out_act); end
        checks++; if (out_col !== 9'd0 || out_row !== 9'd0) begin errors++; $display("[TB] FAIL first_coord: got (%0d,%0d) expected (0,0)", out_col, out_row); end
        @(negedge clk);
        advance_coord();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL accept_clears: got out_valid=%0b expected 0", out_valid); end
        checks++; if (out_col !== 9'(exp_col)) begin errors++; $display("[TB] FAIL col_after_accept: got %0d expected %0d", out_col, exp_col); end
    endtask

    task automatic test_weights();
        logic [5:0]        xs   [2] = '{6'd10, 6'd60};
        logic [8:0]        ws   [2] = '{9'h000, 9'h01F};
        logic signed [15:0] ed  [2] = '{-16'sd270, 16'sd180};
        logic [5:0]        ea   [2] = '{6'd0, 6'd5};
        out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk); set_slice(xs[v], ws[v], 1'b1);
            end
            @(negedge clk); set_slice(6'd0, 9'h000, 1'b0);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL weights_valid[%0d]: got %0b expected 1", v, out_valid); end
            checks++; if (out_data !== ed[v]) begin errors++; $display("[TB] FAIL weights_data[%0d]: got %0d expected %0d", v, out_data, ed[v]); end
            checks++; if (out_act !== ea[v]) begin errors++; $display("[TB] FAIL weights_act[%0d]: got %0d expected %0d", v, out_act, ea[v]); end
            checks++; if (out_col !== 9'(exp_col) || out_row !== 9'(exp_row)) begin errors++; $display("[TB] FAIL weights_coord[%0d]: got (%0d,%0d) expected (%0d,%0d)", v, out_col, out_row, exp_col, exp_row); end
            @(negedge clk);
            advance_coord();
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); set_slice(6'd1, 9'h1FF, 1'b1);
        end
        @(negedge clk); set_slice(6'd0, 9'h000, 1'b0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'sd27) begin errors++; $display("[TB] FAIL held_first: got valid=%0b data=%0d expected 1/27", out_valid, out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_early: got %0b expected 0", overflow); end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); set_slice(6'd2, 9'h1FF, 1'b1);
        end
        @(negedge clk); set_slice(6'd0, 9'h000, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (out_data !== 16'sd27 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL held_unchanged: got valid=%0b data=%0d expected 1/27", out_valid, out_data); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set: got %0b expected 1", overflow); end
        checks++; if (out_col !== 9'(exp_col)) begin errors++; $display("[TB] FAIL held_col: got %0d expected %0d", out_col, exp_col); end
        out_ready = 1'b1;
        @(negedge clk);
        advance_coord();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL overflow_accept: got out_valid=%0b expected 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL overflow_sticky: got %0b expected 1", overflow); end
        checks++; if (out_col !== 9'(exp_col)) begin errors++; $display("[TB] FAIL drop_no_advance: got col %0d expected %0d", out_col, exp_col); end
    endtask

    task automatic test_frame_wrap();
        logic [5:0] xv;
        bit         seen;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_col = 0; exp_row = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_cleared: got %0b expected 0", overflow); end
        out_ready = 1'b1;
        for (int p = 0; p < 197; p++) begin
            xv = 6'(p % 64);
            for (int s = 0; s < 3; s++) begin
                @(negedge clk); set_slice(xv, 9'h1FF, 1'b1);
                @(negedge clk); set_slice(6'd0, 9'h000, 1'b0);
            end
            seen = 1'b0;
            for (int t = 0; t < 4 && !seen; t++) begin
                @(negedge clk);
                if (out_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++; $display("[TB] FAIL frame_timeout[%0d]: got no out_valid expected 1", p);
            end else begin
                if (out_data !== 16'(27 * int'(xv))) begin errors++; $display("[TB] FAIL frame_data[%0d]: got %0d expected %0d", p, out_data, 27 * int'(xv)); end
                checks++;
                if (out_col !== 9'(exp_col) || out_row !== 9'(exp_row)) begin errors++; $display("[TB] FAIL frame_coord[%0d]: got (%0d,%0d) expected (%0d,%0d)", p, out_col, out_row, exp_col, exp_row); end
                checks++;
                if (frame_done !== (exp_col == 13 && exp_row == 13)) begin errors++; $display("[TB] FAIL frame_done[%0d]: got %0b expected %0b", p, frame_done, (exp_col == 13 && exp_row == 13)); end
            end
            advance_coord();
        end
    endtask

    task automatic test_reset_mid_group();
        out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); set_slice(6'd30, 9'h1FF, 1'b1);
        end
        @(negedge clk); set_slice(6'd0, 9'h000, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %0b expected 0", busy); end
        @(negedge clk); rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); set_slice(6'd1, 9'h1FF, 1'b1);
        end
        @(negedge clk); set_slice(6'd0, 9'h000, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_early: got out_valid=%0b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'sd27) begin errors++; $display("[TB] FAIL midreset_data: got valid=%0b data=%0d expected 1/27", out_valid, out_data); end
        checks++; if (out_col !== 9'd0 || out_row !== 9'd0) begin errors++; $display("[TB] FAIL midreset_coord: got (%0d,%0d) expected (0,0)", out_col, out_row); end
    endtask

    initial begin
        set_slice(6'd0, 9'h000, 1'b0);
        test_reset();
        test_back_to_back();
        test_weights();
        test_overflow();
        test_frame_wrap();
        test_reset_mid_group();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
